// File: rtl/reduce_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : reduce_issue_sched
// Purpose  : Round-robin issue scheduler that shares one pipelined adder
//            among the reduction-table slots of a router node. Non-add ops
//            are evaluated at issue time and carried down the same delay
//            line, so every result retires in issue order, tagged by slot.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/a/b/op    - per-slot request, operands and op code
//            slot_clear          - per-slot squash of all in-flight work
//            req_grant           - one-hot combinational grant
//            busy                - per-slot token-in-flight flag
//            add_a/add_b/add_valid, add_s - adder core interface
//            rsp_valid/slot/data/err      - in-order tagged result
//            inflight_count      - tokens currently in the delay line
// Revision : 1.0 - initial release
// ============================================================================
module reduce_issue_sched #(
    parameter int NUM_SLOTS      = 2,
    parameter int SLOT_IDX_WIDTH = 1,
    parameter int PAYLOAD_WIDTH  = 32,
    parameter int OP_WIDTH       = 4,
    parameter int ADDER_LATENCY  = 14,
    parameter int COUNT_WIDTH    = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SLOTS-1:0]               req_valid,
    input  logic [NUM_SLOTS*PAYLOAD_WIDTH-1:0] req_a,
    input  logic [NUM_SLOTS*PAYLOAD_WIDTH-1:0] req_b,
    input  logic [NUM_SLOTS*OP_WIDTH-1:0]      req_op,
    input  logic [NUM_SLOTS-1:0]               slot_clear,
    output logic [NUM_SLOTS-1:0]               req_grant,
    output logic [NUM_SLOTS-1:0]               busy,
    output logic [PAYLOAD_WIDTH-1:0]           add_a,
    output logic [PAYLOAD_WIDTH-1:0]           add_b,
    output logic                               add_valid,
    input  logic [PAYLOAD_WIDTH-1:0]           add_s,
    output logic                               rsp_valid,
    output logic [SLOT_IDX_WIDTH-1:0]          rsp_slot,
    output logic [PAYLOAD_WIDTH-1:0]           rsp_data,
    output logic                               rsp_err,
    output logic [COUNT_WIDTH-1:0]             inflight_count
);

    localparam logic [OP_WIDTH-1:0]       c_OP_ADD = OP_WIDTH'(4'b1111);
    localparam logic [OP_WIDTH-1:0]       c_OP_MAX = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0]       c_OP_MIN = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0]       c_OP_AND = OP_WIDTH'(4'b0011);
    localparam logic [OP_WIDTH-1:0]       c_OP_OR  = OP_WIDTH'(4'b0100);
    localparam logic [SLOT_IDX_WIDTH:0]   c_NUM_SLOTS_EXT = (SLOT_IDX_WIDTH+1)'(NUM_SLOTS);

    typedef struct packed {
        logic                      valid;
        logic [SLOT_IDX_WIDTH-1:0] slot;
        logic                      is_add;
        logic                      err;
        logic [PAYLOAD_WIDTH-1:0]  res;
    } token_t;

    // Entry 0 is the issue register (aligned with add_a/add_b); entries
    // 1..ADDER_LATENCY form the delay line, the last one being the tail.
    token_t r_pipe [0:ADDER_LATENCY];
    token_t w_pipe_nxt [0:ADDER_LATENCY];
    token_t w_new_tok;
    token_t w_tail;

    logic [NUM_SLOTS-1:0]      r_busy;
    logic [SLOT_IDX_WIDTH-1:0] r_rr_ptr;
    logic [PAYLOAD_WIDTH-1:0]  r_add_a;
    logic [PAYLOAD_WIDTH-1:0]  r_add_b;
    logic                      r_add_valid;
    logic [COUNT_WIDTH-1:0]    r_count;

    logic [NUM_SLOTS-1:0]      w_elig;
    logic [NUM_SLOTS-1:0]      w_grant;
    logic                      w_any;
    logic [SLOT_IDX_WIDTH-1:0] w_gnt_idx;
    logic [SLOT_IDX_WIDTH-1:0] w_rr_nxt;
    logic [NUM_SLOTS-1:0]      w_retire;
    logic [COUNT_WIDTH-1:0]    w_count_nxt;
    logic [PAYLOAD_WIDTH-1:0]  w_sel_a;
    logic [PAYLOAD_WIDTH-1:0]  w_sel_b;
    logic [OP_WIDTH-1:0]       w_sel_op;

    // A cleared slot is masked in the same cycle; reset masks every grant.
    assign w_elig = req_valid & ~r_busy & ~slot_clear & {NUM_SLOTS{~rst}};

    // Round-robin: first eligible slot at or after r_rr_ptr, wrapping.
    always_comb begin
        logic [SLOT_IDX_WIDTH:0] cand;
        logic [SLOT_IDX_WIDTH:0] nxt;
        cand      = '0;
        nxt       = '0;
        w_grant   = '0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand = {1'b0, r_rr_ptr} + (SLOT_IDX_WIDTH+1)'(i);
            if (cand >= c_NUM_SLOTS_EXT) cand = cand - c_NUM_SLOTS_EXT;
            if (!w_any && w_elig[cand[SLOT_IDX_WIDTH-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = cand[SLOT_IDX_WIDTH-1:0];
            end
        end
        if (w_any) w_grant[w_gnt_idx] = 1'b1;
        nxt = {1'b0, w_gnt_idx} + (SLOT_IDX_WIDTH+1)'(1);
        if (nxt >= c_NUM_SLOTS_EXT) nxt = '0;
        w_rr_nxt = w_any ? nxt[SLOT_IDX_WIDTH-1:0] : r_rr_ptr;
    end

    assign w_sel_a  = req_a[int'(w_gnt_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign w_sel_b  = req_b[int'(w_gnt_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign w_sel_op = req_op[int'(w_gnt_idx)*OP_WIDTH +: OP_WIDTH];

    // Non-add results are resolved here so the token carries them.
    always_comb begin
        w_new_tok.valid  = w_any;
        w_new_tok.slot   = w_gnt_idx;
        w_new_tok.is_add = 1'b0;
        w_new_tok.err    = 1'b0;
        w_new_tok.res    = w_sel_a;
        case (w_sel_op)
            c_OP_ADD: begin
                w_new_tok.is_add = 1'b1;
                w_new_tok.res    = '0;
            end
            c_OP_MAX: w_new_tok.res = ($signed(w_sel_a) > $signed(w_sel_b)) ? w_sel_a : w_sel_b;
            c_OP_MIN: w_new_tok.res = ($signed(w_sel_a) < $signed(w_sel_b)) ? w_sel_a : w_sel_b;
            c_OP_AND: w_new_tok.res = w_sel_a & w_sel_b;
            c_OP_OR:  w_new_tok.res = w_sel_a | w_sel_b;
            default:  w_new_tok.err = 1'b1;
        endcase
    end

    assign w_tail = r_pipe[ADDER_LATENCY];

    // Shift with squash: any token whose slot is cleared this cycle is
    // invalidated as it moves; the count is the population of survivors.
    always_comb begin
        w_pipe_nxt[0] = w_new_tok;
        w_count_nxt   = COUNT_WIDTH'(w_new_tok.valid);
        for (int i = 1; i <= ADDER_LATENCY; i++) begin
            w_pipe_nxt[i]       = r_pipe[i-1];
            w_pipe_nxt[i].valid = r_pipe[i-1].valid & ~slot_clear[r_pipe[i-1].slot];
            w_count_nxt         = w_count_nxt + COUNT_WIDTH'(w_pipe_nxt[i].valid);
        end
    end

    always_comb begin
        w_retire = '0;
        if (w_tail.valid) w_retire[w_tail.slot] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ADDER_LATENCY; i++) r_pipe[i] <= '0;
            r_busy      <= '0;
            r_rr_ptr    <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            for (int i = 0; i <= ADDER_LATENCY; i++) r_pipe[i] <= w_pipe_nxt[i];
            r_busy      <= (r_busy & ~w_retire & ~slot_clear) | w_grant;
            r_rr_ptr    <= w_rr_nxt;
            r_add_valid <= w_any;
            r_count     <= w_count_nxt;
            if (w_any) begin
                r_add_a <= w_sel_a;
                r_add_b <= w_sel_b;
            end
        end
    end

    assign req_grant      = w_grant;
    assign busy           = r_busy;
    assign add_a          = r_add_a;
    assign add_b          = r_add_b;
    assign add_valid      = r_add_valid;
    assign inflight_count = r_count;
    // A clear arriving with the tail token for the same slot drops it.
    assign rsp_valid      = w_tail.valid & ~slot_clear[w_tail.slot];
    assign rsp_slot       = w_tail.slot;
    assign rsp_data       = w_tail.is_add ? add_s : w_tail.res;
    assign rsp_err        = w_tail.err;

endmodule
`default_nettype wire

// File: tb/tb_reduce_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduce_issue_sched
// Purpose  : Scoreboard bench for reduce_issue_sched with directed scenarios
//            followed by randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduce_issue_sched;

    localparam int c_N   = 2;
    localparam int c_LAT = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [63:0]   req_a;
    logic [63:0]   req_b;
    logic [7:0]    req_op;
    logic [1:0]    slot_clear;
    logic [1:0]    req_grant;
    logic [1:0]    busy;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_valid;
    logic [31:0]   add_s;
    logic          rsp_valid;
    logic [0:0]    rsp_slot;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [4:0]    inflight_count;

    reduce_issue_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .slot_clear(slot_clear), .req_grant(req_grant), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_slot(rsp_slot), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .inflight_count(inflight_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit started     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the FP adder core: integer sum, except 1.0 + 2.0 = 3.0.
    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    logic [31:0] apipe [c_LAT];
    always @(posedge clk) begin
        apipe[0] <= fadd(add_a, add_b);
        for (int k = 1; k < c_LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_s = apipe[c_LAT-1];

    // Expected result of one operation, straight from the op table.
    function automatic logic [32:0] ref_op(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'b1111: return {1'b0, fadd(a, b)};
            4'b0001: return {1'b0, ($signed(a) > $signed(b)) ? a : b};
            4'b0010: return {1'b0, ($signed(a) < $signed(b)) ? a : b};
            4'b0011: return {1'b0, a & b};
            4'b0100: return {1'b0, a | b};
            default: return {1'b1, a};
        endcase
    endfunction

    typedef struct {
        int          slot;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  mbusy = '0;
    int          rr    = 0;
    bit          mav   = 0;
    logic [31:0] ma    = '0;
    logic [31:0] mb    = '0;

    // Reference model: decides the grant, tracks busy/in-flight work and
    // pushes the expected tagged response with its due cycle.
    always @(negedge clk) begin
        int          gs;
        int          s;
        logic [1:0]  eg;
        logic [32:0] r;
        exp_t        e;
        exp_t        keep[$];
        gs = -1;
        if (!rst) begin
            for (int k = 0; k < c_N; k++) begin
                s = (rr + k) % c_N;
                if (gs < 0 && req_valid[s] && !mbusy[s] && !slot_clear[s]) gs = s;
            end
        end
        eg = (gs >= 0) ? 2'(1 << gs) : 2'b00;
        if (started) begin
            chk("grant", req_grant, eg);
            chk("busy", busy, mbusy);
            chk("inflight", inflight_count, sb.size());
            chk("add_valid", add_valid, mav);
            chk("add_a", add_a, ma);
            chk("add_b", add_b, mb);
        end
        if (rst) begin
            sb.delete();
            mbusy = '0; rr = 0; mav = 0; ma = '0; mb = '0;
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) mbusy[sb[0].slot] = 1'b0;
            for (int c = 0; c < c_N; c++) begin
                if (slot_clear[c]) begin
                    keep.delete();
                    foreach (sb[i]) if (sb[i].slot != c) keep.push_back(sb[i]);
                    sb = keep;
                    mbusy[c] = 1'b0;
                end
            end
            mav = (gs >= 0);
            if (gs >= 0) begin
                ma = req_a[gs*32 +: 32];
                mb = req_b[gs*32 +: 32];
                r  = ref_op(req_op[gs*4 +: 4], ma, mb);
                e.slot = gs; e.data = r[31:0]; e.err = r[32]; e.due = cyc + 1 + c_LAT;
                sb.push_back(e);
                mbusy[gs] = 1'b1;
                rr = (gs + 1) % c_N;
            end
        end
        started = 1;
    end

    // Monitor: pops and compares whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (started) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_spurious", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_slot", rsp_slot, e.slot);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 1'b0, 1'b1);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_slot(int s, logic [31:0] a, logic [31:0] b, logic [3:0] op);
        req_a[s*32 +: 32] = a;
        req_b[s*32 +: 32] = b;
        req_op[s*4 +: 4]  = op;
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 5))
            0, 1: return 4'b1111;
            2:    return 4'b0001;
            3:    return 4'b0010;
            4:    return ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b0100;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1'b1; req_valid = '0; slot_clear = '0;
        req_a = '0; req_b = '0; req_op = '0;
        tick(3);
        rst = 1'b0;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_slot", rsp_slot, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        tick(2);

        // Single add 1.0 + 2.0 on slot 0.
        set_slot(0, 32'h3F80_0000, 32'h4000_0000, 4'b1111);
        req_valid = 2'b01; tick(1);
        req_valid = 2'b00; tick(18);

        // In-block ops on slot 1: max, and, unsupported.
        set_slot(1, 32'hFFFF_FFFB, 32'h0000_0003, 4'b0001);
        req_valid = 2'b10; tick(1); req_valid = 2'b00; tick(16);
        set_slot(1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0011);
        req_valid = 2'b10; tick(1); req_valid = 2'b00; tick(16);
        set_slot(1, 32'h1234_5678, 32'h0000_FF00, 4'b0111);
        req_valid = 2'b10; tick(1); req_valid = 2'b00; tick(16);

        // Contention: both slots request continuously.
        set_slot(0, 32'd100, 32'd7, 4'b1111);
        set_slot(1, 32'd200, 32'd9, 4'b1111);
        req_valid = 2'b11; tick(50);
        req_valid = 2'b00; tick(20);

        // Squash slot 0 seven cycles after its grant.
        set_slot(0, 32'd5, 32'd6, 4'b1111);
        req_valid = 2'b01; tick(1);
        req_valid = 2'b00; tick(6);
        slot_clear = 2'b01; tick(1);
        slot_clear = 2'b00; tick(16);

        // Clear versus grant on an idle slot 0.
        set_slot(1, 32'd1, 32'd2, 4'b0100);
        req_valid = 2'b11; slot_clear = 2'b01; tick(1);
        req_valid = 2'b00; slot_clear = 2'b00; tick(18);

        // Reset with two tokens in flight, then slot 0 must win first.
        req_valid = 2'b11; tick(2);
        req_valid = 2'b00; tick(4);
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(20);
        req_valid = 2'b11; tick(1);
        req_valid = 2'b00; tick(18);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < c_N; s++) set_slot(s, $urandom, $urandom, rand_op());
            req_valid  = 2'($urandom_range(0, 3));
            slot_clear = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            tick(1);
        end
        req_valid = 2'b00; slot_clear = 2'b00;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
